lote_estadisticas: RTL

- Statistics and supervision stage directly downstream of the inspection Moore FSM; it consumes the 2-bit verdict bus E alongside the Mealy protocol FSM.
- Counts accepted and rejected products and closes a batch after BATCH accepts.
- Latches an alarm after REJ_LIMIT consecutive rejects.
- Outputs are registered and intended for the top-level uo_out[7:4] and a debug bus.

---
 rtl/lote_estadisticas_if.sv | 22 ++
 rtl/lote_estadisticas.sv | 91 +++++++++
 2 files changed

// File: rtl/lote_estadisticas_if.sv
// Verdict/acknowledge inputs and statistics outputs of the batch
// statistics stage, grouped for connection to the inspection front end.
interface lote_estadisticas_if;
  logic [1:0] E;
  logic       ack;
  logic [7:0] ok_count;
  logic [7:0] rej_count;
  logic [3:0] consec_rej;
  logic       batch_done;
  logic       alarm;
  logic [1:0] st;

  modport master (
    output E, ack,
    input  ok_count, rej_count, consec_rej, batch_done, alarm, st
  );

  modport slave (
    input  E, ack,
    output ok_count, rej_count, consec_rej, batch_done, alarm, st
  );
endinterface

// File: rtl/lote_estadisticas.sv
// Batch statistics stage: counts accept/reject verdict edges, closes a batch
// after BATCH accepts and latches an alarm after REJ_LIMIT consecutive rejects.
module lote_estadisticas #(
  parameter int BATCH     = 10,
  parameter int REJ_LIMIT = 3
) (
  input logic clk,
  input logic reset,
  lote_estadisticas_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_DONE  = 2'b01,
    S_ALARM = 2'b10
  } state_t;

  localparam logic [8:0] BATCH_W = 9'(BATCH);
  localparam logic [4:0] LIMIT_W = 5'(REJ_LIMIT);

  state_t     state, state_next;
  logic [1:0] e_prev;
  logic [7:0] ok_count, ok_next;
  logic [7:0] rej_count, rej_next;
  logic [3:0] consec, consec_next;
  logic       acc_ev, rej_ev;

  // A verdict held over several cycles counts once; 10->11 still yields a reject.
  assign acc_ev = (bus.E == 2'b10) && (e_prev != 2'b10);
  assign rej_ev = (bus.E == 2'b11) && (e_prev != 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      e_prev    <= 2'b00;
      ok_count  <= 8'd0;
      rej_count <= 8'd0;
      consec    <= 4'd0;
    end else begin
      state     <= state_next;
      e_prev    <= bus.E;
      ok_count  <= ok_next;
      rej_count <= rej_next;
      consec    <= consec_next;
    end
  end

  always_comb begin
    state_next  = state;
    ok_next     = ok_count;
    rej_next    = rej_count;
    consec_next = consec;
    case (state)
      S_RUN: begin
        if (acc_ev) begin
          ok_next     = ok_count + 8'd1;
          consec_next = 4'd0;
          if ({1'b0, ok_count} + 9'd1 == BATCH_W) state_next = S_DONE;
        end else if (rej_ev) begin
          rej_next    = (rej_count == 8'hFF) ? rej_count : rej_count + 8'd1;
          consec_next = consec + 4'd1;
          if ({1'b0, consec} + 5'd1 == LIMIT_W) state_next = S_ALARM;
        end
      end
      S_DONE: begin
        if (bus.ack) begin
          state_next  = S_RUN;
          ok_next     = 8'd0;
          rej_next    = 8'd0;
          consec_next = 4'd0;
        end
      end
      S_ALARM: begin
        // Totals stay visible after the alarm; only the reject run restarts.
        if (bus.ack) begin
          state_next  = S_RUN;
          consec_next = 4'd0;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  assign bus.ok_count   = ok_count;
  assign bus.rej_count  = rej_count;
  assign bus.consec_rej = consec;
  assign bus.batch_done = (state == S_DONE);
  assign bus.alarm      = (state == S_ALARM);
  assign bus.st         = state;

endmodule
